// File: rtl/edf_tdma_queue_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : edf_tdma_queue_scheduler
// Purpose  : Picks which per-core request queue forwards its head packet to
//            the shared memory-side port. Two policies are supported: TDMA
//            with per-core slot lengths, and non-preemptive EDF with per-core
//            relative deadlines. The grant is registered, and the one-hot pop
//            is decoded combinationally from consumed & activate.
// Revision : 1.0 - initial release
// ============================================================================
module edf_tdma_queue_scheduler #(
    parameter int CORE_COUNT    = 4,
    parameter int COUNTER_WIDTH = 32,
    parameter int MODE_WIDTH    = 1,
    localparam int c_SEL_W      = $clog2(CORE_COUNT)
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic [MODE_WIDTH-1:0]                    mode,
    input  logic [CORE_COUNT-1:0][COUNTER_WIDTH-1:0] periods,
    input  logic [CORE_COUNT-1:0][COUNTER_WIDTH-1:0] deadlines,
    input  logic [CORE_COUNT-1:0]                    nonempty,
    input  logic                                     consumed,
    output logic [c_SEL_W-1:0]                       select,
    output logic                                     activate,
    output logic [CORE_COUNT-1:0]                    pop,
    output logic [c_SEL_W-1:0]                       slot
);

    localparam int c_LEAVES = 1 << c_SEL_W;
    localparam int c_NODES  = 2 * c_LEAVES - 1;

    // Registered state
    logic                     r_run;        // low only until the first edge after reset
    logic [MODE_WIDTH-1:0]    r_mode;
    logic [COUNTER_WIDTH-1:0] r_count;
    logic [c_SEL_W-1:0]       r_slot;
    logic [c_SEL_W-1:0]       r_select;
    logic                     r_activate;
    logic [CORE_COUNT-1:0]    r_nonempty_q;
    logic [COUNTER_WIDTH-1:0] r_timer [CORE_COUNT];

    // Combinational helpers
    logic                     w_pop;
    logic                     w_mode_chg;
    logic                     w_restart;
    logic [COUNTER_WIDTH-1:0] w_period;
    logic                     w_slot_end;
    logic [c_SEL_W-1:0]       w_slot_inc;
    logic [COUNTER_WIDTH-1:0] w_count_nxt;
    logic [c_SEL_W-1:0]       w_slot_nxt;
    logic [CORE_COUNT-1:0]    w_rise;
    logic [c_SEL_W-1:0]       w_sel_nxt;
    logic                     w_act_nxt;
    logic                     w_min_vld;
    logic [c_SEL_W-1:0]       w_min_idx;

    // Min-tree nodes: node n has children 2n+1 (lower indices) and 2n+2
    logic [COUNTER_WIDTH-1:0] w_nval [c_NODES];
    logic [c_SEL_W-1:0]       w_nidx [c_NODES];
    logic                     w_nvld [c_NODES];

    assign w_pop      = consumed & r_activate;
    assign pop        = w_pop ? (CORE_COUNT'(1) << r_select) : '0;
    assign select     = r_select;
    assign activate   = r_activate;
    assign slot       = r_slot;

    // A mode change is only meaningful once the block is running; the first
    // edge after reset simply captures whatever mode is applied.
    assign w_mode_chg = r_run && (mode != r_mode);
    assign w_restart  = !r_run || w_mode_chg;
    assign w_rise     = nonempty & ~r_nonempty_q;

    // A zero-length slot behaves as a one-cycle slot.
    assign w_period   = periods[r_slot];
    assign w_slot_end = (w_period == '0) || (r_count == (w_period - COUNTER_WIDTH'(1)));
    assign w_slot_inc = (r_slot == c_SEL_W'(CORE_COUNT - 1)) ? '0 : (r_slot + c_SEL_W'(1));

    // TDMA slot counter next state: restart on first edge or mode change
    always_comb begin
        w_count_nxt = r_count + COUNTER_WIDTH'(1);
        w_slot_nxt  = r_slot;
        if (w_restart) begin
            w_count_nxt = '0;
            w_slot_nxt  = '0;
        end else if (w_slot_end) begin
            w_count_nxt = '0;
            w_slot_nxt  = w_slot_inc;
        end
    end

    // Min-tree leaves: a queue that rises this cycle competes with its fresh deadline
    generate
        for (genvar i = 0; i < c_LEAVES; i++) begin : g_leaf
            if (i < CORE_COUNT) begin : g_real
                assign w_nvld[c_LEAVES-1+i] = nonempty[i];
                assign w_nval[c_LEAVES-1+i] = w_rise[i] ? deadlines[i] : r_timer[i];
                assign w_nidx[c_LEAVES-1+i] = c_SEL_W'(i);
            end else begin : g_pad
                assign w_nvld[c_LEAVES-1+i] = 1'b0;
                assign w_nval[c_LEAVES-1+i] = '0;
                assign w_nidx[c_LEAVES-1+i] = '0;
            end
        end

        // Internal nodes: left child wins ties so the lowest index is preferred
        for (genvar n = 0; n < c_LEAVES - 1; n++) begin : g_node
            logic w_take_left;
            assign w_take_left = w_nvld[2*n+1] &&
                                 (!w_nvld[2*n+2] || (w_nval[2*n+1] <= w_nval[2*n+2]));
            assign w_nvld[n] = w_nvld[2*n+1] || w_nvld[2*n+2];
            assign w_nval[n] = w_take_left ? w_nval[2*n+1] : w_nval[2*n+2];
            assign w_nidx[n] = w_take_left ? w_nidx[2*n+1] : w_nidx[2*n+2];
        end
    endgenerate

    assign w_min_vld = w_nvld[0];
    assign w_min_idx = w_nidx[0];

    // Grant next state: mode change or pop forces a bubble, otherwise apply policy
    always_comb begin
        w_act_nxt = 1'b0;
        w_sel_nxt = r_select;
        if (w_mode_chg || w_pop) begin
            w_act_nxt = 1'b0;
        end else if (mode == '0) begin
            w_sel_nxt = w_slot_nxt;
            w_act_nxt = nonempty[w_slot_nxt] && (periods[w_slot_nxt] != '0);
        end else if (r_activate) begin
            w_act_nxt = nonempty[r_select];
        end else if (w_min_vld) begin
            w_act_nxt = 1'b1;
            w_sel_nxt = w_min_idx;
        end
    end

    // Control and grant registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_run        <= 1'b0;
            r_mode       <= '0;
            r_count      <= '0;
            r_slot       <= '0;
            r_select     <= '0;
            r_activate   <= 1'b0;
            r_nonempty_q <= '0;
        end else begin
            r_run        <= 1'b1;
            r_mode       <= mode;
            r_count      <= w_count_nxt;
            r_slot       <= w_slot_nxt;
            r_select     <= w_sel_nxt;
            r_activate   <= w_act_nxt;
            r_nonempty_q <= nonempty;
        end
    end

    // EDF timers: reload on a fresh head, otherwise count down while waiting
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < CORE_COUNT; i++) begin
                r_timer[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CORE_COUNT; i++) begin
                if (w_rise[i] || (pop[i] && nonempty[i])) begin
                    r_timer[i] <= deadlines[i];
                end else if (nonempty[i] && (r_timer[i] != '0)) begin
                    r_timer[i] <= r_timer[i] - COUNTER_WIDTH'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_edf_tdma_queue_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_edf_tdma_queue_scheduler
// Purpose  : Directed self-checking bench for edf_tdma_queue_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_edf_tdma_queue_scheduler;

    localparam int N = 4;
    localparam int W = 32;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic [0:0]          mode  = 1'b0;
    logic [N-1:0][W-1:0] periods;
    logic [N-1:0][W-1:0] deadlines;
    logic [N-1:0]        nonempty = '0;
    logic                consumed = 1'b0;
    logic [1:0]          select;
    logic                activate;
    logic [N-1:0]        pop;
    logic [1:0]          slot;

    int n_assert = 0;
    int n_fail   = 0;

    edf_tdma_queue_scheduler #(
        .CORE_COUNT   (N),
        .COUNTER_WIDTH(W),
        .MODE_WIDTH   (1)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .mode     (mode),
        .periods  (periods),
        .deadlines(deadlines),
        .nonempty (nonempty),
        .consumed (consumed),
        .select   (select),
        .activate (activate),
        .pop      (pop),
        .slot     (slot)
    );

    always #5 clock = ~clock;

    // Safety net so the run always ends
    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            periods[i]   = 32'd4;
            deadlines[i] = 32'd0;
        end

        // Asynchronous reset before any clock edge
        #2 reset = 1'b0;
        #1;
        chk("rst_activate", {31'b0, activate}, 32'd0);
        chk("rst_select",   {30'b0, select},   32'd0);
        chk("rst_slot",     {30'b0, slot},     32'd0);
        chk("rst_pop",      {28'b0, pop},      32'd0);

        // TDMA rotation with 4-cycle slots
        nonempty = 4'b1111;
        tick();
        tick();
        reset = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("rot_slot",     {30'b0, slot},     (k / 4) % 4);
            chk("rot_select",   {30'b0, select},   (k / 4) % 4);
            chk("rot_activate", {31'b0, activate}, 32'd1);
        end

        // Reset mid-grant on slot 2
        for (int k = 20; k < 25; k++) tick();
        chk("mid_pre_select",   {30'b0, select},   32'd2);
        chk("mid_pre_activate", {31'b0, activate}, 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_activate", {31'b0, activate}, 32'd0);
        chk("mid_select",   {30'b0, select},   32'd0);
        chk("mid_slot",     {30'b0, slot},     32'd0);
        consumed = 1'b1;
        #1;
        chk("mid_pop", {28'b0, pop}, 32'd0);
        consumed = 1'b0;
        reset    = 1'b1;
        tick();
        chk("mid_rel_activate", {31'b0, activate}, 32'd1);
        chk("mid_rel_select",   {30'b0, select},   32'd0);
        tick(); tick(); tick();
        chk("mid_rel_slot_last", {30'b0, slot}, 32'd0);
        tick();
        chk("mid_rel_slot_next", {30'b0, slot}, 32'd1);

        // TDMA with zero-length slots and pops
        reset = 1'b0;
        #1;
        periods[0] = 32'h100;
        periods[1] = 32'd0;
        periods[2] = 32'd0;
        periods[3] = 32'd0;
        nonempty   = 4'b0001;
        reset      = 1'b1;
        tick();
        for (int p = 0; p < 3; p++) begin
            chk("z_grant_activate", {31'b0, activate}, 32'd1);
            chk("z_grant_select",   {30'b0, select},   32'd0);
            consumed = 1'b1;
            #1;
            chk("z_pop", {28'b0, pop}, 32'h1);
            tick();
            consumed = (p == 1);
            #1;
            chk("z_bubble_activate", {31'b0, activate}, 32'd0);
            chk("z_bubble_pop",      {28'b0, pop},      32'd0);
            tick();
        end
        consumed = 1'b0;
        for (int k = 0; k < 249; k++) tick();
        chk("z_end_slot",     {30'b0, slot},     32'd0);
        chk("z_end_activate", {31'b0, activate}, 32'd1);
        for (int s = 1; s < 4; s++) begin
            tick();
            chk("z_short_slot",     {30'b0, slot},     s);
            chk("z_short_activate", {31'b0, activate}, 32'd0);
        end
        tick();
        chk("z_wrap_slot",     {30'b0, slot},     32'd0);
        chk("z_wrap_activate", {31'b0, activate}, 32'd1);

        // EDF ordering by deadline
        reset = 1'b0;
        #1;
        mode         = 1'b1;
        deadlines[0] = 32'd40;
        deadlines[1] = 32'd10;
        deadlines[2] = 32'd30;
        deadlines[3] = 32'd20;
        nonempty     = 4'b0000;
        reset        = 1'b1;
        tick();
        chk("edf_idle_activate", {31'b0, activate}, 32'd0);
        nonempty = 4'b1111;
        tick();
        chk("edf_g1_activate", {31'b0, activate}, 32'd1);
        chk("edf_g1_select",   {30'b0, select},   32'd1);
        consumed = 1'b1;
        #1;
        chk("edf_pop1", {28'b0, pop}, 32'h2);
        tick();
        consumed = 1'b0;
        nonempty = 4'b1101;
        chk("edf_b1_activate", {31'b0, activate}, 32'd0);
        tick();
        chk("edf_g3_select", {30'b0, select}, 32'd3);
        consumed = 1'b1;
        #1;
        chk("edf_pop3", {28'b0, pop}, 32'h8);
        tick();
        consumed = 1'b0;
        nonempty = 4'b0101;
        chk("edf_b2_activate", {31'b0, activate}, 32'd0);
        tick();
        chk("edf_g2_select", {30'b0, select}, 32'd2);
        consumed = 1'b1;
        #1;
        chk("edf_pop2", {28'b0, pop}, 32'h4);
        tick();
        consumed = 1'b0;
        nonempty = 4'b0001;
        tick();
        chk("edf_g0_select",   {30'b0, select},   32'd0);
        chk("edf_g0_activate", {31'b0, activate}, 32'd1);
        consumed = 1'b1;
        #1;
        chk("edf_pop0", {28'b0, pop}, 32'h1);
        tick();
        consumed = 1'b0;
        nonempty = 4'b0000;
        tick();
        chk("edf_empty_activate", {31'b0, activate}, 32'd0);

        // EDF ties go to the lowest index
        reset = 1'b0;
        #1;
        for (int i = 0; i < N; i++) deadlines[i] = 32'd5;
        reset = 1'b1;
        tick();
        nonempty = 4'b1111;
        tick();
        chk("tie_select",   {30'b0, select},   32'd0);
        chk("tie_activate", {31'b0, activate}, 32'd1);

        // EDF saturation at zero, and a head-fall releasing the grant
        reset = 1'b0;
        #1;
        nonempty = '0;
        for (int i = 0; i < N; i++) deadlines[i] = 32'd0;
        deadlines[3] = 32'd2;
        nonempty     = 4'b0111;
        reset        = 1'b1;
        tick();
        chk("sat_select",   {30'b0, select},   32'd0);
        chk("sat_activate", {31'b0, activate}, 32'd1);
        for (int k = 0; k < 4; k++) tick();
        chk("sat_hold_select", {30'b0, select}, 32'd0);
        nonempty = 4'b1110;
        tick();
        chk("fall_activate", {31'b0, activate}, 32'd0);
        chk("fall_pop",      {28'b0, pop},      32'd0);
        tick();
        chk("sat_next_select",   {30'b0, select},   32'd1);
        chk("sat_next_activate", {31'b0, activate}, 32'd1);

        // Non-preemption, then mode switch during a grant
        reset = 1'b0;
        #1;
        nonempty     = '0;
        deadlines[0] = 32'd1;
        deadlines[1] = 32'd50;
        deadlines[2] = 32'd30;
        deadlines[3] = 32'd50;
        for (int i = 0; i < N; i++) periods[i] = 32'd4;
        nonempty     = 4'b0100;
        reset        = 1'b1;
        tick();
        chk("np_g2_select", {30'b0, select}, 32'd2);
        nonempty = 4'b0101;
        tick();
        chk("np_hold1_select", {30'b0, select}, 32'd2);
        tick();
        chk("np_hold2_select", {30'b0, select}, 32'd2);
        consumed = 1'b1;
        #1;
        chk("np_pop2", {28'b0, pop}, 32'h4);
        tick();
        consumed = 1'b0;
        nonempty = 4'b0001;
        chk("np_bubble_activate", {31'b0, activate}, 32'd0);
        tick();
        chk("np_g0_select",   {30'b0, select},   32'd0);
        chk("np_g0_activate", {31'b0, activate}, 32'd1);
        chk("np_pre_slot",    {30'b0, slot},     32'd1);
        mode     = 1'b0;
        consumed = 1'b1;
        #1;
        chk("mc_pop", {28'b0, pop}, 32'h1);
        tick();
        consumed = 1'b0;
        chk("mc_activate", {31'b0, activate}, 32'd0);
        chk("mc_slot",     {30'b0, slot},     32'd0);
        tick();
        chk("mc_tdma_activate", {31'b0, activate}, 32'd1);
        chk("mc_tdma_slot",     {30'b0, slot},     32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/edf_tdma_queue_scheduler.md
# edf_tdma_queue_scheduler

Selects which per-core request queue may forward its head packet to the shared memory-side port in the non-AXI domain. It supports two policies: TDMA with per-core slot lengths, and non-preemptive EDF with per-core relative deadlines. It sits between the per-core packet queues, which report non-empty, and the output stage, which asserts `consumed` when it takes a packet. It issues a one-hot pop to the selected queue.

## Interface
- `CORE_COUNT`, default 4: number of queues/requesters.
- `COUNTER_WIDTH`, default 32: width of the period, deadline and timer values.
- `MODE_WIDTH`, default 1: width of the policy select; 0 = TDMA, 1 = EDF.

- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `mode`  in  MODE_WIDTH  policy select.
- `periods`  in  [CORE_COUNT][COUNTER_WIDTH]  TDMA slot length in cycles, per core.
- `deadlines`  in  [CORE_COUNT][COUNTER_WIDTH]  EDF relative deadline in cycles, per core.
- `nonempty`  in  CORE_COUNT  bit i high means queue i holds at least one packet.
- `consumed`  in  1  the output stage takes the granted packet this cycle.
- `select`  out  $clog2(CORE_COUNT)  index of the granted queue (registered).
- `activate`  out  1  grant valid (registered).
- `pop`  out  CORE_COUNT  one-hot dequeue strobe; combinational, equal to `consumed & activate` decoded at `select`.
- `slot`  out  $clog2(CORE_COUNT)  current TDMA slot index (registered).

## Operation
- **Reset (`reset`=0)**: `activate`=0, `select`=0, `slot`=0, slot counter=0, all EDF timers=0, `pop`=0.
- **Handshake**
  - A pop occurs in a cycle with `activate`=1 and `consumed`=1; that cycle `pop[select]`=1.
  - The edge after a pop forces `activate`=0 for exactly one cycle (bubble), so queue status can settle.
  - Maximum throughput is therefore one packet per 2 cycles.
  - `consumed` while `activate`=0 is ignored; `pop` stays 0.
- **TDMA (`mode`=0)**
  - The slot counter increments every cycle.
  - When the counter equals `periods[slot]`-1, the counter goes to 0 and `slot` advances by 1, wrapping CORE_COUNT-1 to 0.
  - `periods[slot]`=0 is treated as a 1-cycle slot with the grant forced off.
  - Next-state grant: `select`=`slot` (value after any advance), `activate`=`nonempty[slot]`.
  - A grant does not survive a slot boundary.
- **EDF (`mode`=1)**
  - Each core has a timer of COUNTER_WIDTH bits.
  - The timer reloads to `deadlines[i]` on a rising edge of `nonempty[i]`, or on `pop[i]` while `nonempty[i]` remains 1 (fresh head).
  - Otherwise, while `nonempty[i]`=1, the timer decrements, saturating at 0. While `nonempty[i]`=0 it holds its value.
  - Timers run in both modes.
  - When `activate`=0 (and not in a bubble): grant the non-empty queue with the smallest timer; ties go to the lowest index. If no queue is non-empty, `activate` stays 0.
  - Non-preemptive: while `activate`=1, `select` is held until a pop occurs or `nonempty[select]` falls. A fall drops `activate` the next cycle, with no pop.
- **Mode change**
  - `mode` differing from its registered copy forces `activate`=0 next cycle.
  - It also resets `slot` and the slot counter to 0.
  - A pop in that same cycle still completes.
- **Comparator**: a combinational min-tree over CORE_COUNT timers, with unsigned compare.

## Timing
- Grant latency: `nonempty[i]` rising in cycle t gives `activate`=1 in cycle t+1 (EDF, or TDMA with `slot`=i).
- After a pop in cycle t: `activate`=0 in t+1; the new grant is visible in t+2.
- The TDMA slot of length P occupies exactly P cycles of `slot`=k; the first slot after reset starts on the first edge with `reset` high.
- `pop` is combinational from `consumed`; there is no registered path from `consumed` to `pop`.
- Reset is asserted asynchronously, so outputs go to reset values without waiting for a clock edge. Deassertion takes effect at the next edge.

## Test plan
- **Reset mid-grant**: drive `reset`=0 while `activate`=1 and `select`=2 -> `activate`=0, `select`=0, `slot`=0 immediately; after release, `slot`=0 with the counter at 0.
- **TDMA rotation**: `periods`={4,4,4,4}, `nonempty`=4'b1111, `consumed`=0 -> `slot`/`select` = 0×4 cycles, 1×4, 2×4, 3×4, then 0 again at cycle 16; `activate`=1 throughout.
- **TDMA zero slots with pops**: `periods`={0x100,0,0,0}, `nonempty`=4'b0001, `consumed` pulsed 1-of-2 cycles -> `pop`=4'b0001 on each pulse while in slot 0, bubble cycle after each pop; slots 1-3 last 1 cycle each with `activate`=0.
- **EDF ordering**: `mode`=1, `deadlines`={40,10,30,20}, `nonempty` all rising in cycle t -> grant at t+1 to 1; after pop with `nonempty[1]` dropped, grants go 3, then 2, then 0, each 2 cycles after the previous pop.
- **EDF ties and saturation**: `deadlines`={5,5,5,5}, all non-empty -> `select`=0. With `deadlines`={0,0,0,0} -> `select`=0 and timers stay 0, no underflow.
- **Non-preemption and mode switch**: in EDF, grant held on queue 2 (timer 30) while queue 0 rises with deadline 1 -> `select` stays 2 until its pop, then 0. Toggling `mode` to 0 during a grant -> `activate`=0 next cycle, `slot`=0.
